elevator_car_controller: RTL and testbench
==========================================

ELEVATOR_CAR_CONTROLLER -- requirements
Module: elevator_car_controller

Interface
REQ-001 Parameter TRAVEL_CYCLES, default 4, clock cycles to move one floor (legal 1..15).
REQ-002 Parameter DOOR_CYCLES, default 3, clock cycles the door stays open (legal 1..15).
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 assignedButton  input  14  hall calls assigned to this car by the dispatcher; bit 2f-2 = UP call at floor f, bit 2f-1 = DOWN call at floor f, f = 1..7.
REQ-006 cabinButton  input  7  cabin floor-select pulses; bit f-1 = floor f.
REQ-007 currentFloor  output  3  car position, 3'b001..3'b111.
REQ-008 direction  output  2  STOP=00, UP=10, DOWN=01; 11 never driven.
REQ-009 doorOpen  output  1  high while door is open.
REQ-010 servedButton  output  14  one-cycle pulse, same bit map as assignedButton, marking hall calls answered.

Function
REQ-011 Pending(f) = assignedButton hall bits at f OR latched cabin request at f; cabin pulses latch into a 7-bit register, cleared only when served.
REQ-012 FSM states IDLE, MOVE, DOOR; direction = STOP in IDLE and DOOR, UP/DOWN in MOVE.
REQ-013 IDLE: Pending(currentFloor) -> DOOR next cycle; else any Pending above -> MOVE UP; else any Pending below -> MOVE DOWN; else stay IDLE. Above wins over below.
REQ-014 MOVE: 4-bit travel counter counts TRAVEL_CYCLES cycles, then currentFloor steps +1 (UP) or -1 (DOWN) and counter restarts.
REQ-015 On each floor step, the car stops (-> DOOR) if new floor has cabin request, hall call matching travel direction, or any call with no Pending further in travel direction; else continues MOVE.
REQ-016 currentFloor saturates: UP never leaves 7, DOWN never leaves 1; reaching 7 or 1 forces DOOR if Pending there, else IDLE.
REQ-017 On DOOR entry: servedButton pulses both hall bits of currentFloor that are set in assignedButton; cabin latch bit for currentFloor clears; door counter loads DOOR_CYCLES; doorOpen=1.
REQ-018 DOOR: doorOpen held DOOR_CYCLES cycles; a new Pending(currentFloor) during DOOR re-pulses servedButton and reloads the door counter (reopen).
REQ-019 DOOR exit: Pending in previous travel direction -> MOVE same direction; else Pending opposite -> MOVE reversed; else IDLE. Exit from an IDLE-entered DOOR applies REQ-013 ordering.
REQ-020 Cabin pulse for currentFloor while IDLE -> DOOR next cycle; while MOVE, latched and handled at that floor on the next pass.
REQ-021 Hall bit dropped by dispatcher before arrival is not served and causes no stop.
REQ-022 Floor step and new request in same cycle: request is evaluated in the stop decision of that step.

Reset
REQ-023 On reset: state IDLE, currentFloor=3'b001, direction=STOP, doorOpen=0, servedButton=0, cabin latch=0, counters=0.
REQ-024 Reset asserted mid-MOVE or mid-DOOR aborts immediately to REQ-023 values; no served pulse on reset release.

Structure
REQ-025 Shared package holds STOP/UP/DOWN/UPDOWN codes, ON/OFF, floor bounds FLOOR_MIN=1, FLOOR_MAX=7, and the state encoding.
REQ-026 One sub-module car_timer (loadable 4-bit down-counter with done flag) instantiated twice: travel and door.
REQ-027 Above/below/at-floor request scans are combinational inside the top module.

Verification
REQ-028 Reset, assignedButton bit 8 (UP at 5) held: direction=UP after 1 cycle, floor reaches 5 after 4x4 cycles, servedButton=14'h0100 one cycle, doorOpen 3 cycles, then IDLE.
REQ-029 Floor 1, cabinButton 7 and hall DOWN at 4 (bit 7): car passes 4 without stopping, stops at 7, reverses, stops at 4, servedButton=14'h0080.
REQ-030 Door open at floor 3, hall UP at 3 (bit 4) asserted mid-door: servedButton=14'h0010 re-pulses, doorOpen extended to 3 cycles from reassertion.
REQ-031 Moving UP from 2 toward 6, reset asserted at floor 4: outputs instantly floor 1, STOP, doorOpen 0; no activity with no inputs.
REQ-032 Calls at 2 and 6 simultaneously from floor 4 IDLE: car moves UP first, serves 6, then DOWN to 2.
REQ-033 Hall UP at 7 / DOWN at 1 and TRAVEL_CYCLES=1: floor never exceeds 7 or drops below 1; direction never 11.

Source files
------------

// File: rtl/elevator_car_controller_pkg.sv
// Shared definitions for the elevator car controller.
// Holds direction codes, door levels, floor bounds, FSM state encoding
// and small helpers that build floor-indexed request masks.
package elevator_car_controller_pkg;

  localparam logic [1:0] STOP   = 2'b00;
  localparam logic [1:0] UP     = 2'b10;
  localparam logic [1:0] DOWN   = 2'b01;
  localparam logic [1:0] UPDOWN = 2'b11;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  localparam logic [2:0] FLOOR_MIN = 3'd1;
  localparam logic [2:0] FLOOR_MAX = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  // Floors strictly above f, as a 7-bit floor vector (bit f-1 = floor f).
  function automatic logic [6:0] mask_above(input logic [2:0] f);
    return 7'h7F << f;
  endfunction

  // Floors strictly below f.
  function automatic logic [6:0] mask_below(input logic [2:0] f);
    return (7'h01 << (f - 3'd1)) - 7'h01;
  endfunction

  // Both hall-call bits (UP, DOWN) of floor f in the 14-bit hall map.
  function automatic logic [13:0] hall_mask(input logic [2:0] f);
    return 14'h0003 << {f - 3'd1, 1'b0};
  endfunction

endpackage

// File: rtl/elevator_car_controller_car_timer.sv
// car_timer: loadable 4-bit down-counter.
// Ports: clk, rst (async, active-high), load (load load_val), en (count
// down while non-zero), load_val, done (count has reached zero).
module car_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] load_val,
  output logic       done
);

  logic [3:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign done = (count == 4'd0);

endmodule

// File: rtl/elevator_car_controller.sv
// elevator_car_controller: single-car controller for floors 1..7.
// Ports: clk, reset (async, active-high), assignedButton (hall calls from
// the dispatcher, bit 2f-2 = UP at f, bit 2f-1 = DOWN at f), cabinButton
// (cabin floor-select pulses), currentFloor, direction (STOP/UP/DOWN),
// doorOpen, servedButton (one-cycle pulse of answered hall calls).
module elevator_car_controller
  import elevator_car_controller_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] assignedButton,
  input  logic [6:0]  cabinButton,
  output logic [2:0]  currentFloor,
  output logic [1:0]  direction,
  output logic        doorOpen,
  output logic [13:0] servedButton
);

  // Timers hold N-1 so that done marks the last cycle of an N-cycle interval.
  localparam logic [3:0] TRAV_LOAD = 4'(TRAVEL_CYCLES - 1);
  localparam logic [3:0] DOOR_LOAD = 4'(DOOR_CYCLES - 1);

  state_t      state, state_n;
  logic [2:0]  floor_n, door_floor, step_floor, fi, si, di;
  logic [1:0]  move_dir, dir_n, door_seen, seen_n, hall_at;
  logic [6:0]  cab_latch, cab_n, cab_req, hall_up, hall_dn, pend;
  logic [13:0] served_n;
  logic        pend_at, above_any, below_any, beyond, match, at_end, stop_here;
  logic        go_up, go_dn, enter_door;
  logic        trav_load, trav_en, trav_done, door_load, door_en, door_done;

  car_timer u_travel (
    .clk(clk), .rst(reset), .load(trav_load), .en(trav_en),
    .load_val(TRAV_LOAD), .done(trav_done)
  );

  car_timer u_door (
    .clk(clk), .rst(reset), .load(door_load), .en(door_en),
    .load_val(DOOR_LOAD), .done(door_done)
  );

  // Request scans: raw cabin pulses count immediately so a press in the
  // same cycle as a floor step takes part in that step's stop decision.
  always_comb begin
    for (int i = 0; i < 7; i++) begin
      hall_up[i] = assignedButton[2*i];
      hall_dn[i] = assignedButton[2*i+1];
    end
  end

  assign cab_req   = cab_latch | cabinButton;
  assign pend      = hall_up | hall_dn | cab_req;
  assign fi        = currentFloor - 3'd1;
  assign pend_at   = pend[fi];
  assign hall_at   = {hall_dn[fi], hall_up[fi]};
  assign above_any = |(pend & mask_above(currentFloor));
  assign below_any = |(pend & mask_below(currentFloor));

  // Floor reached at the end of the current travel interval (saturating).
  always_comb begin
    step_floor = currentFloor;
    if (move_dir == UP) begin
      if (currentFloor != FLOOR_MAX) step_floor = currentFloor + 3'd1;
    end else if (currentFloor != FLOOR_MIN) begin
      step_floor = currentFloor - 3'd1;
    end
  end

  assign si        = step_floor - 3'd1;
  assign beyond    = (move_dir == UP) ? |(pend & mask_above(step_floor))
                                      : |(pend & mask_below(step_floor));
  assign match     = (move_dir == UP) ? hall_up[si] : hall_dn[si];
  assign at_end    = (move_dir == UP) ? (step_floor == FLOOR_MAX)
                                      : (step_floor == FLOOR_MIN);
  assign stop_here = cab_req[si] | match | (pend[si] & ~beyond);

  // Door exit keeps the previous travel direction when it still has work;
  // a door opened from IDLE (move_dir = STOP) prefers above over below.
  assign go_up = (move_dir == DOWN) ? (above_any & ~below_any) : above_any;
  assign go_dn = (move_dir == DOWN) ? below_any : (below_any & ~above_any);

  always_comb begin
    state_n    = state;
    floor_n    = currentFloor;
    dir_n      = move_dir;
    served_n   = '0;
    cab_n      = cab_req;
    seen_n     = door_seen;
    trav_load  = 1'b0;
    trav_en    = 1'b0;
    door_load  = 1'b0;
    door_en    = 1'b0;
    enter_door = 1'b0;
    door_floor = currentFloor;
    unique case (state)
      IDLE: begin
        if (pend_at) begin
          enter_door = 1'b1;
          dir_n      = STOP;
        end else if (above_any) begin
          state_n   = MOVE;
          dir_n     = UP;
          trav_load = 1'b1;
        end else if (below_any) begin
          state_n   = MOVE;
          dir_n     = DOWN;
          trav_load = 1'b1;
        end
      end
      MOVE: begin
        if (trav_done) begin
          floor_n    = step_floor;
          door_floor = step_floor;
          trav_load  = 1'b1;
          if (at_end) begin
            if (pend[si]) enter_door = 1'b1;
            else          state_n    = IDLE;
          end else if (stop_here) begin
            enter_door = 1'b1;
          end
        end else begin
          trav_en = 1'b1;
        end
      end
      DOOR: begin
        // Only a hall bit that rises during the door, or a fresh cabin
        // press for this floor, reopens; a call held since arrival does not.
        if (((hall_at & ~door_seen) != 2'b00) || cabinButton[fi]) begin
          enter_door = 1'b1;
        end else begin
          seen_n = hall_at;
          if (door_done) begin
            if (go_up) begin
              state_n   = MOVE;
              dir_n     = UP;
              trav_load = 1'b1;
            end else if (go_dn) begin
              state_n   = MOVE;
              dir_n     = DOWN;
              trav_load = 1'b1;
            end else begin
              state_n = IDLE;
            end
          end else begin
            door_en = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (enter_door) begin
      state_n   = DOOR;
      served_n  = assignedButton & hall_mask(door_floor);
      cab_n[di] = 1'b0;
      seen_n    = {hall_dn[di], hall_up[di]};
      door_load = 1'b1;
    end
  end

  assign di = door_floor - 3'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      currentFloor <= FLOOR_MIN;
      move_dir     <= STOP;
      cab_latch    <= '0;
      servedButton <= '0;
      door_seen    <= 2'b00;
    end else begin
      state        <= state_n;
      currentFloor <= floor_n;
      move_dir     <= dir_n;
      cab_latch    <= cab_n;
      servedButton <= served_n;
      door_seen    <= seen_n;
    end
  end

  assign direction = ((state == MOVE) && (move_dir != UPDOWN)) ? move_dir : STOP;
  assign doorOpen  = (state == DOOR) ? ON : OFF;

endmodule

// File: tb/tb_elevator_car_controller.sv
module tb_elevator_car_controller;

  logic        clk;
  logic        reset;
  logic [13:0] assignedButton, assigned2;
  logic [6:0]  cabinButton, cabin2;
  logic [2:0]  currentFloor, floor2;
  logic [1:0]  direction, dir2;
  logic        doorOpen, door2;
  logic [13:0] servedButton, served2;

  int passed = 0;
  int fails  = 0;
  int total  = 0;
  int cyc, c, act, bad, maxf, minf;
  logic seen7, back1;

  elevator_car_controller dut (
    .clk(clk), .reset(reset), .assignedButton(assignedButton),
    .cabinButton(cabinButton), .currentFloor(currentFloor),
    .direction(direction), .doorOpen(doorOpen), .servedButton(servedButton)
  );

  elevator_car_controller #(.TRAVEL_CYCLES(1), .DOOR_CYCLES(3)) dut_fast (
    .clk(clk), .reset(reset), .assignedButton(assigned2),
    .cabinButton(cabin2), .currentFloor(floor2),
    .direction(dir2), .doorOpen(door2), .servedButton(served2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic wait_door(input int budget, output int n);
    n = 0;
    while (doorOpen !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_close(output int n);
    n = 0;
    while (doorOpen === 1'b1 && n < 20) begin
      n++;
      tick();
    end
  endtask

  task automatic press(input logic [6:0] cab);
    cabinButton = cab;
    tick();
    cabinButton = '0;
  endtask

  initial begin
    reset = 1'b1;
    assignedButton = '0;
    cabinButton = '0;
    assigned2 = '0;
    cabin2 = '0;
    tick();
    tick();
    chk("rst_floor", currentFloor, 3'd1);
    chk("rst_dir", direction, 2'b00);
    chk("rst_door", doorOpen, 1'b0);
    chk("rst_served", servedButton, 14'h0);
    reset = 1'b0;
    tick();

    // UP call at floor 5 from floor 1
    assignedButton = 14'h0100;
    tick();
    chk("a_dir_up", direction, 2'b10);
    wait_door(40, cyc);
    chk("a_door_reached", doorOpen, 1'b1);
    chk("a_travel_cycles", cyc, 16);
    chk("a_floor5", currentFloor, 3'd5);
    chk("a_served", servedButton, 14'h0100);
    assignedButton = '0;
    tick();
    chk("a_served_one_cycle", servedButton, 14'h0);
    wait_close(c);
    chk("a_door_cycles", c + 1, 3);
    chk("a_idle_dir", direction, 2'b00);
    tick();
    tick();
    chk("a_stays_idle", direction, 2'b00);

    // Go to floor 4, then calls at 2 and 6 together
    press(7'b0001000);
    wait_door(40, cyc);
    chk("b_floor4", currentFloor, 3'd4);
    wait_close(c);
    press(7'b0100010);
    chk("b_up_first", direction, 2'b10);
    wait_door(40, cyc);
    chk("b_serve6", currentFloor, 3'd6);
    wait_close(c);
    chk("b_then_down", direction, 2'b01);
    wait_door(40, cyc);
    chk("b_serve2", currentFloor, 3'd2);
    wait_close(c);

    // Door at floor 3, UP call at 3 raised mid-door reopens it
    press(7'b0000100);
    wait_door(40, cyc);
    chk("c_floor3", currentFloor, 3'd3);
    tick();
    assignedButton = 14'h0010;
    tick();
    chk("c_repulse", servedButton, 14'h0010);
    assignedButton = '0;
    wait_close(c);
    chk("c_door_extended", c, 3);
    chk("c_idle", direction, 2'b00);

    // Moving UP from 2 toward 6, reset at floor 4
    press(7'b0000010);
    wait_door(40, cyc);
    wait_close(c);
    chk("d_floor2", currentFloor, 3'd2);
    press(7'b0100000);
    cyc = 0;
    while (currentFloor !== 3'd4 && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("d_at4_moving", direction, 2'b10);
    reset = 1'b1;
    #1;
    chk("d_rst_floor", currentFloor, 3'd1);
    chk("d_rst_dir", direction, 2'b00);
    chk("d_rst_door", doorOpen, 1'b0);
    tick();
    reset = 1'b0;
    act = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (direction !== 2'b00 || doorOpen !== 1'b0 || servedButton !== 14'h0 ||
          currentFloor !== 3'd1)
        act++;
    end
    chk("d_quiet_after_reset", act, 0);

    // Cabin 7 plus DOWN call at 4: pass 4, stop at 7, reverse, stop at 4
    cabinButton = 7'b1000000;
    assignedButton = 14'h0080;
    tick();
    cabinButton = '0;
    chk("e_dir_up", direction, 2'b10);
    wait_door(60, cyc);
    chk("e_first_stop7", currentFloor, 3'd7);
    chk("e_served7_none", servedButton, 14'h0);
    wait_close(c);
    chk("e_reverse", direction, 2'b01);
    wait_door(60, cyc);
    chk("e_stop4", currentFloor, 3'd4);
    chk("e_served4", servedButton, 14'h0080);
    assignedButton = '0;
    wait_close(c);
    chk("e_idle", direction, 2'b00);

    // Fast instance: calls at the floor bounds
    assigned2 = 14'h1002;
    tick();
    seen7 = 1'b0;
    back1 = 1'b0;
    bad = 0;
    maxf = 0;
    minf = 7;
    for (int i = 0; i < 40; i++) begin
      if (dir2 === 2'b11 || floor2 < 3'd1 || floor2 > 3'd7) bad++;
      if (int'(floor2) > maxf) maxf = int'(floor2);
      if (int'(floor2) < minf) minf = int'(floor2);
      if (served2[12]) begin
        seen7 = 1'b1;
        assigned2 = (assigned2 & ~served2) | 14'h0002;
      end else if (served2 != 14'h0) begin
        if (seen7) back1 = 1'b1;
        assigned2 = assigned2 & ~served2;
      end
      tick();
    end
    chk("f_no_bad_output", bad, 0);
    chk("f_max_floor", maxf, 7);
    chk("f_min_floor", minf, 1);
    chk("f_served7", seen7, 1'b1);
    chk("f_back_to1", back1, 1'b1);
    chk("f_end_floor1", floor2, 3'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
